crc5_check: RTL and testbench

- Receive-side USB CRC5 checker; the counterpart of the token-packet CRC5 generator.
- Sits behind the receive bit-unstuffer. Consumes the 11-bit token field (ADDR+ENDP) followed by the 5 transmitted CRC bits, serially, one bit per strobe.
- Recomputes CRC5 (x^5+x^2+1, seed all-ones) over all 16 bits, compares the register to the USB residual, and holds a pass/fail verdict plus the captured field until the consumer acknowledges.

---
 rtl/crc5_check.sv | 130 +++++++++++++
 tb/tb_crc5_check.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc5_check.sv
// crc5_check: receive-side USB token CRC5 checker (x^5+x^2+1, all-ones seed).
// Shifts in the 11-bit token field followed by its 5 transmitted CRC bits,
// one bit per strobe. After the last bit the register is compared with the
// USB residual. The pass/fail verdict and the captured field are held until
// the consumer acknowledges.
module crc5_check #(
  parameter int         DATA_W   = 11,
  parameter logic [4:0] SEED     = 5'b11111,
  parameter logic [4:0] RESIDUAL = 5'b01100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_start,
  input  logic              s_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic              chk_ack,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              crc_ok,
  output logic              crc_err,
  output logic [DATA_W-1:0] field_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value of the first CRC bit, and of the final bit of the packet.
  localparam logic [4:0] FIELD_CNT = 5'(DATA_W);
  localparam logic [4:0] LAST_CNT  = 5'(DATA_W + 4);

  state_t              state_q, state_d;
  logic [4:0]          crc_q, crc_d, crc_upd;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   field_q, field_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                fb;

  // One LFSR step of the CRC register for the bit currently on s_in.
  always_comb begin
    fb      = crc_q[4] ^ s_in;
    crc_upd = {crc_q[3], crc_q[2], crc_q[1] ^ fb, crc_q[0], fb};
  end

  // Next-state logic. abort overrides everything except reset.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    field_d = field_q;
    ok_d    = ok_q;
    err_d   = err_q;

    if (abort) begin
      // Drop the packet without a verdict. The partial field is left visible.
      state_d = IDLE;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (chk_start) begin
            crc_d   = SEED;
            cnt_d   = '0;
            field_d = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            crc_d = crc_upd;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q < FIELD_CNT) begin
              for (int i = 0; i < DATA_W; i++) begin
                if (cnt_q == 5'(i)) field_d[i] = s_in;
              end
            end
            if (cnt_q == LAST_CNT) begin
              // The verdict uses the register value that includes this final bit.
              ok_d    = (crc_upd == RESIDUAL);
              err_d   = (crc_upd != RESIDUAL);
              state_d = DONE;
            end
          end
        end
        DONE: begin
          // A chk_start arriving together with chk_ack is ignored. The
          // consumer must re-assert it once the checker is back in IDLE.
          if (chk_ack) begin
            ok_d    = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= SEED;
      cnt_q   <= '0;
      field_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      field_q <= field_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign chk_busy  = (state_q == SHIFT);
  assign chk_done  = (state_q == DONE);
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign field_out = field_q;

endmodule

// File: tb/tb_crc5_check.sv
// tb_crc5_check: randomized scoreboard bench for crc5_check. The expected
// verdict comes from a polynomial-division model of the token CRC5 generator:
// a packet is good exactly when its received CRC bits equal the generator's
// CRC for the received field.
module tb_crc5_check;
  localparam int DATA_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              chk_start, s_in, bit_valid, abort, chk_ack;
  logic              chk_busy, chk_done, crc_ok, crc_err;
  logic [DATA_W-1:0] field_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit                ok;
    logic [DATA_W-1:0] fld;
    int                cyc;
  } exp_t;

  exp_t sbq[$];
  logic done_prev = 1'b0;

  crc5_check #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chk_start (chk_start),
    .s_in      (s_in),
    .bit_valid (bit_valid),
    .abort     (abort),
    .chk_ack   (chk_ack),
    .chk_busy  (chk_busy),
    .chk_done  (chk_done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .field_out (field_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Generator CRC5 by long division. The seed contributes 11111*x^11. The
  // field contributes M(x)*x^5, where the first bit sent is the top coefficient.
  // The return value holds the transmitted bits in send order (bit 0 first):
  // the complemented remainder, MSB first.
  function automatic logic [4:0] gen_crc(input logic [DATA_W-1:0] fld);
    logic [15:0] v;
    logic [4:0]  r;
    v = 16'hF800;
    for (int i = 0; i < DATA_W; i++)
      if (fld[i]) v ^= (16'd1 << (15 - i));
    for (int k = 15; k >= 5; k--)
      if (v[k]) v ^= (16'h0025 << (k - 5));
    for (int j = 0; j < 5; j++) r[j] = ~v[4 - j];
    return r;
  endfunction

  // Monitor: on each rising chk_done, pop the oldest expectation and check it.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      if (chk_done && !done_prev) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got chk_done=1 want 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("verdict_ok", crc_ok, e.ok);
          chk("verdict_err", crc_err, !e.ok);
          chk("field", field_out, e.fld);
          chk("done_latency", cyc, e.cyc);
        end
      end
      done_prev <= chk_done;
    end
  end

  // Start a packet, then send 16 bits (field then CRC bits), optionally with a
  // one-cycle gap after each strobe and random chk_start noise mid-packet.
  task automatic send_pkt(input logic [DATA_W-1:0] fld, input logic [4:0] cb,
                          input bit gap, input bit noisy_start);
    logic [15:0] seq;
    exp_t        e;
    seq = {cb, fld};
    @(negedge clk); chk_start = 1'b1;
    @(negedge clk); chk_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      s_in      = seq[i];
      chk_start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 15) begin
        e.ok  = (cb == gen_crc(fld));
        e.fld = fld;
        e.cyc = cyc + 1;
        sbq.push_back(e);
      end
      @(negedge clk);
      if (gap && i != 15) begin
        bit_valid = 1'b0;
        s_in      = 1'($urandom_range(0, 1));
        chk_start = 1'b0;
        @(negedge clk);
      end
    end
    bit_valid = 1'b0;
    s_in      = 1'b0;
    chk_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && !chk_done; n++) @(negedge clk);
    if (!chk_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got chk_done=0 want 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic do_ack();
    chk_ack = 1'b1;
    @(negedge clk);
    chk_ack = 1'b0;
    chk("ack_done", chk_done, 1'b0);
    chk("ack_busy", chk_busy, 1'b0);
    chk("ack_ok", crc_ok, 1'b0);
    chk("ack_err", crc_err, 1'b0);
  endtask

  task automatic good_pkt(input bit gap);
    logic [DATA_W-1:0] f;
    f = DATA_W'($urandom);
    send_pkt(f, gen_crc(f), gap, 1'b0);
    wait_done();
    do_ack();
  endtask

  initial begin
    logic [DATA_W-1:0] f;
    logic [15:0]       pk;
    rst_n = 1'b0; chk_start = 1'b0; s_in = 1'b0; bit_valid = 1'b0;
    abort = 1'b0; chk_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", chk_busy, 1'b0);
    chk("rst_done", chk_done, 1'b0);
    chk("rst_ok", crc_ok, 1'b0);
    chk("rst_err", crc_err, 1'b0);
    chk("rst_field", field_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero field, CRC bits 0,1,0,0,0 in send order: good.
    send_pkt('0, 5'b00010, 1'b0, 1'b0);
    wait_done();
    do_ack();
    // Same packet with the last bit flipped: bad.
    send_pkt('0, 5'b10010, 1'b0, 1'b0);
    wait_done();
    do_ack();

    // Generator-produced packets with bit_valid toggling.
    repeat (4) good_pkt(1'b1);

    // Abort after 7 accepted bits.
    f = DATA_W'($urandom);
    @(negedge clk); chk_start = 1'b1;
    @(negedge clk); chk_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; s_in = f[i];
      @(negedge clk);
    end
    bit_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", chk_busy, 1'b0);
    chk("abort_done", chk_done, 1'b0);
    chk("abort_partial_field", field_out[6:0], f[6:0]);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", chk_busy, 1'b0);
    good_pkt(1'b0);

    // Held verdict under bit_valid/chk_start noise, then start+ack together.
    f = DATA_W'($urandom);
    send_pkt(f, gen_crc(f), 1'b0, 1'b0);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      bit_valid = 1'b1; chk_start = 1'b1; s_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i == 0 || i == 19) begin
        chk("hold_done", chk_done, 1'b1);
        chk("hold_ok", crc_ok, 1'b1);
        chk("hold_field", field_out, f);
      end
    end
    chk_ack = 1'b1;
    @(negedge clk);
    chk_ack = 1'b0; chk_start = 1'b0; bit_valid = 1'b0;
    chk("startack_done", chk_done, 1'b0);
    chk("startack_busy", chk_busy, 1'b0);
    chk("startack_ok", crc_ok, 1'b0);

    // Random packets: random gaps, start noise, and single-bit corruption.
    for (int n = 0; n < 12; n++) begin
      f  = DATA_W'($urandom);
      pk = {gen_crc(f), f};
      if ($urandom_range(0, 1) == 1) pk[$urandom_range(0, 15)] ^= 1'b1;
      send_pkt(pk[10:0], pk[15:11], 1'($urandom_range(0, 1)), 1'b1);
      wait_done();
      do_ack();
    end

    // Abort while in DONE drops the verdict.
    f = DATA_W'($urandom);
    send_pkt(f, gen_crc(f), 1'b0, 1'b0);
    wait_done();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortdone_done", chk_done, 1'b0);
    chk("abortdone_ok", crc_ok, 1'b0);

    // Asynchronous reset mid-SHIFT.
    @(negedge clk); chk_start = 1'b1;
    @(negedge clk); chk_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; s_in = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", chk_busy, 1'b0);
    chk("arst_done", chk_done, 1'b0);
    chk("arst_ok", crc_ok, 1'b0);
    chk("arst_err", crc_err, 1'b0);
    chk("arst_field", field_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_busy", chk_busy, 1'b0);
    chk("arst_idle_done", chk_done, 1'b0);
    good_pkt(1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
